random_word_harvester: RTL and testbench



---
 rtl/random_word_harvester_pkg.sv | 28 ++
 rtl/random_word_harvester_debiaser.sv | 64 ++++++
 rtl/random_word_harvester.sv | 179 +++++++++++++++++
 tb/tb_random_word_harvester.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/random_word_harvester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : random_word_harvester_pkg
// Description : Definitions shared by the entropy-consumer blocks: the
//               von Neumann pair-state encoding, the default sizing constants
//               and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package random_word_harvester_pkg;

    // Pair FSM: waiting for the first sample of a pair, or holding it.
    typedef enum logic [0:0] {
        VN_IDLE       = 1'b0,
        VN_HAVE_FIRST = 1'b1
    } vn_state_t;

    localparam int c_WORD_WIDTH_DEF  = 32;
    localparam int c_SYNC_STAGES_DEF = 2;
    localparam int c_SAMPLE_DIV_DEF  = 4;
    localparam int c_RCT_LIMIT_DEF   = 64;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/random_word_harvester_debiaser.sv
`default_nettype none
// ============================================================================
// Module      : von_neumann_debiaser
// Description : Pairs successive strobed raw samples (a,b). a!=b emits bit a,
//               a==b emits nothing. Dropping enable discards a half pair.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               strobe          a raw sample is taken this cycle
//               raw_bit         synchronised raw entropy bit
//               enable          harvesting enabled
//               out_valid       a debiased bit is emitted this cycle
//               out_bit         the emitted bit (meaningful with out_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module von_neumann_debiaser
    import random_word_harvester_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    input  logic raw_bit,
    input  logic enable,
    output logic out_valid,
    output logic out_bit
);

    vn_state_t r_state;
    vn_state_t w_state_next;
    logic      r_first;
    logic      w_first_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= VN_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_first <= w_first_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_first_next = r_first;
        out_valid    = 1'b0;
        out_bit      = r_first;
        if (!enable) begin
            w_state_next = VN_IDLE;
        end else if (strobe) begin
            case (r_state)
                VN_IDLE: begin
                    w_first_next = raw_bit;
                    w_state_next = VN_HAVE_FIRST;
                end
                VN_HAVE_FIRST: begin
                    out_valid    = (r_first != raw_bit);
                    w_state_next = VN_IDLE;
                end
                default: w_state_next = VN_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/random_word_harvester.sv
`default_nettype none
// ============================================================================
// Module      : random_word_harvester
// Description : Synchronises an asynchronous metastable entropy bit, samples
//               it every SAMPLE_DIV clocks, debiases it (von Neumann) and
//               packs the result MSB-first into words offered on a
//               valid/ready interface.
//               Optional macro RANDOM_HEALTH_TEST_EN adds a repetition-count
//               health test with a sticky fault output.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               metastable_in   raw entropy bit, asynchronous to clk
//               enable          harvesting enabled
//               rnd_data        random word, stable while valid && !ready
//               rnd_valid       rnd_data holds an unconsumed word
//               rnd_ready       consumer accepts
//               fault           sticky health-test failure
// Revision    : 1.0 - initial release
// ============================================================================
module random_word_harvester
    import random_word_harvester_pkg::*;
#(
    parameter int WORD_WIDTH  = c_WORD_WIDTH_DEF,
    parameter int SYNC_STAGES = c_SYNC_STAGES_DEF,
    parameter int SAMPLE_DIV  = c_SAMPLE_DIV_DEF,
    parameter int RCT_LIMIT   = c_RCT_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  metastable_in,
    input  logic                  enable,
    output logic [WORD_WIDTH-1:0] rnd_data,
    output logic                  rnd_valid,
    input  logic                  rnd_ready,
    output logic                  fault
);

    localparam int c_DIV_W = cnt_width(SAMPLE_DIV);
    localparam int c_CNT_W = cnt_width(WORD_WIDTH + 1);

    // ------------------------------------------------------------------
    // Synchroniser and sample divider
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DIV_W-1:0]     r_div;
    logic                   w_raw;
    logic                   w_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], metastable_in};
        end
    end

    assign w_raw    = r_sync[SYNC_STAGES-1];
    assign w_strobe = enable && (r_div == c_DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (!enable || w_strobe) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Debiaser
    // ------------------------------------------------------------------
    logic w_vn_valid;
    logic w_vn_bit;

    von_neumann_debiaser u_debiaser (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe    (w_strobe),
        .raw_bit   (w_raw),
        .enable    (enable),
        .out_valid (w_vn_valid),
        .out_bit   (w_vn_bit)
    );

    // ------------------------------------------------------------------
    // Optional repetition-count health test
    // ------------------------------------------------------------------
    logic w_fault;

`ifdef RANDOM_HEALTH_TEST_EN
    localparam int c_RCT_W = cnt_width(RCT_LIMIT + 1);

    // r_run == 0 means no sample seen yet; otherwise the length of the
    // current run of identical samples, saturating at RCT_LIMIT.
    logic [c_RCT_W-1:0] r_run;
    logic               r_last;
    logic               r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= '0;
            r_last  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            if (r_run >= c_RCT_W'(RCT_LIMIT)) begin
                r_fault <= 1'b1;
            end
            if (w_strobe) begin
                r_last <= w_raw;
                if ((r_run != '0) && (w_raw == r_last)) begin
                    if (r_run < c_RCT_W'(RCT_LIMIT)) begin
                        r_run <= r_run + c_RCT_W'(1);
                    end
                end else begin
                    r_run <= c_RCT_W'(1);
                end
            end
        end
    end

    assign w_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    assign fault = w_fault;

    // ------------------------------------------------------------------
    // Shifter and output register
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] r_sh;
    logic [c_CNT_W-1:0]    r_count;
    logic [WORD_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  w_transfer;
    logic                  w_full;
    logic                  w_load;

    assign w_transfer = r_valid && rnd_ready;
    assign w_full     = (r_count == c_CNT_W'(WORD_WIDTH));
    assign w_load     = w_full && (!r_valid || w_transfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh    <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_fault) begin
            r_sh    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_data  <= r_sh;
                r_valid <= 1'b1;
            end else if (w_transfer) begin
                r_valid <= 1'b0;
            end

            // A bit emitted in the load cycle starts the next word.
            if (w_load) begin
                r_count <= w_vn_valid ? c_CNT_W'(1) : '0;
                if (w_vn_valid) begin
                    r_sh <= {r_sh[WORD_WIDTH-2:0], w_vn_bit};
                end
            end else if (w_vn_valid && !w_full) begin
                r_sh    <= {r_sh[WORD_WIDTH-2:0], w_vn_bit};
                r_count <= r_count + c_CNT_W'(1);
            end
        end
    end

    assign rnd_data  = r_data;
    // Masked combinationally so a fresh fault hides the word at once.
    assign rnd_valid = r_valid && !w_fault;

endmodule
`default_nettype wire

// File: tb/tb_random_word_harvester.sv
`default_nettype none
// ============================================================================
// Module      : tb_random_word_harvester
// Description : Self-checking bench: directed scenarios plus random traffic
//               compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_random_word_harvester;

    localparam int W   = 8;
    localparam int SD  = 1;
    localparam int SS  = 2;
    localparam int RCT = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         metastable_in = 1'b0;
    logic         enable = 1'b0;
    logic         rnd_ready = 1'b1;
    logic [W-1:0] rnd_data;
    logic         rnd_valid;
    logic         fault;

    int checks = 0;
    int errors = 0;

    random_word_harvester #(
        .WORD_WIDTH  (W),
        .SYNC_STAGES (SS),
        .SAMPLE_DIV  (SD),
        .RCT_LIMIT   (RCT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .metastable_in (metastable_in),
        .enable        (enable),
        .rnd_data      (rnd_data),
        .rnd_valid     (rnd_valid),
        .rnd_ready     (rnd_ready),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Behavioural model: delay line for the synchroniser, pending bits as a
    // queue (first bit becomes the word MSB), one output slot.
    bit           m_pipe[$];
    int           m_div;
    bit           m_have;
    bit           m_a;
    bit           m_q[$];
    logic [W-1:0] m_data;
    bit           m_valid;
    bit           m_fault;
    int           m_run;
    bit           m_last;

    task automatic m_reset();
        m_pipe = {};
        for (int i = 0; i < SS; i++) m_pipe.push_back(1'b0);
        m_div = 0; m_have = 0; m_a = 0; m_q = {};
        m_data = '0; m_valid = 0; m_fault = 0; m_run = 0; m_last = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: predict from current inputs, clock, compare.
    task automatic cycle();
        bit r, strobe, emit, eb, xfer, load, nf;
        logic [W-1:0] w;
        r      = m_pipe[0];
        strobe = enable && (m_div == SD - 1);
        emit   = 0;
        eb     = 0;
        if (!enable) m_have = 0;
        else if (strobe) begin
            if (!m_have) begin m_a = r; m_have = 1; end
            else begin m_have = 0; emit = (m_a != r); eb = m_a; end
        end
        m_div = (!enable || strobe) ? 0 : m_div + 1;
        xfer = m_valid && rnd_ready;
        load = (m_q.size() == W) && (!m_valid || xfer);
        if (m_fault) begin
            m_valid = 0; m_q = {};
        end else if (load) begin
            w = '0;
            for (int i = 0; i < W; i++) w[W-1-i] = m_q[i];
            m_data = w; m_valid = 1; m_q = {};
            if (emit) m_q.push_back(eb);
        end else begin
            if (xfer) m_valid = 0;
            if (emit && m_q.size() < W) m_q.push_back(eb);
        end
        nf = m_fault;
`ifdef RANDOM_HEALTH_TEST_EN
        nf = m_fault || (m_run >= RCT);
        if (strobe) begin
            if (m_run > 0 && r == m_last) m_run = (m_run < RCT) ? m_run + 1 : RCT;
            else m_run = 1;
            m_last = r;
        end
`endif
        m_fault = nf;
        m_pipe.push_back(metastable_in);
        void'(m_pipe.pop_front());
        @(posedge clk);
        #1;
        check("valid", {31'd0, rnd_valid}, {31'd0, m_valid && !m_fault});
        if (m_valid && !m_fault) check("data", {24'd0, rnd_data}, {24'd0, m_data});
        check("fault", {31'd0, fault}, {31'd0, m_fault});
    endtask

    // Sample i of bits is seen by the pair logic on the (i+2)th clock;
    // enable for that clock is ens[i].
    task automatic run_seq(input logic [63:0] bits, input logic [63:0] ens, input int n);
        for (int i = 0; i < n + 2; i++) begin
            metastable_in = (i < n) ? bits[i] : 1'b0;
            enable        = (i >= 2) ? ens[i-2] : 1'b0;
            cycle();
        end
        enable = 1'b0;
        metastable_in = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", {31'd0, rnd_valid}, 32'd0);
        check("rst_data", {24'd0, rnd_data}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        m_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    logic [63:0] c_ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        m_reset();
        #7;
        check("reset_valid", {31'd0, rnd_valid}, 32'd0);
        check("reset_data", {24'd0, rnd_data}, 32'd0);
        check("reset_fault", {31'd0, fault}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // (1,0) x8 -> 0xFF for exactly one cycle
        rnd_ready = 1'b1;
        run_seq(64'h5555, c_ALL, 16);
        cycle();
        check("t1_valid", {31'd0, rnd_valid}, 32'd1);
        check("t1_data", {24'd0, rnd_data}, 32'hFF);
        cycle();
        check("t1_drain", {31'd0, rnd_valid}, 32'd0);

        // (1,0),(0,1) alternating -> 0xAA
        run_seq(64'h9999, c_ALL, 16);
        cycle();
        check("t2_data", {24'd0, rnd_data}, 32'hAA);
        cycle();
        // equal pairs only -> nothing
        run_seq(64'hCCCC, c_ALL, 16);
        cycle();
        check("t2_nowords", {31'd0, rnd_valid}, 32'd0);

        // back-pressure: word1 stays, word2 held, word3 dropped
        rnd_ready = 1'b0;
        run_seq(64'h0000_5555_AAAA_5555, c_ALL, 48);
        check("t3_hold_valid", {31'd0, rnd_valid}, 32'd1);
        check("t3_hold_data", {24'd0, rnd_data}, 32'hFF);
        rnd_ready = 1'b1;
        cycle();
        rnd_ready = 1'b0;
        check("t3_reload_valid", {31'd0, rnd_valid}, 32'd1);
        check("t3_reload_data", {24'd0, rnd_data}, 32'h00);
        cycle();
        rnd_ready = 1'b1;
        cycle();
        check("t3_empty", {31'd0, rnd_valid}, 32'd0);

        // enable drop after first sample of a pair discards it
        do_reset();
        run_seq(64'hB, 64'hD, 4);
        run_seq(64'h1555, c_ALL, 14);
        cycle();
        check("t4_data", {24'd0, rnd_data}, 32'h7F);
        cycle();

`ifdef RANDOM_HEALTH_TEST_EN
        // stuck source trips the repetition-count test
        run_seq(64'hFFFFF, c_ALL, 20);
        cycle();
        check("t5_fault", {31'd0, fault}, 32'd1);
        check("t5_valid", {31'd0, rnd_valid}, 32'd0);
        do_reset();
`endif

        // reset mid-word with a pending output word
        rnd_ready = 1'b0;
        run_seq(64'h5555, c_ALL, 16);
        cycle();
        run_seq(64'h155, c_ALL, 10);
        check("t6_pending", {31'd0, rnd_valid}, 32'd1);
        do_reset();
        rnd_ready = 1'b1;
        run_seq(64'hAAAA, c_ALL, 16);
        cycle();
        check("t6_valid", {31'd0, rnd_valid}, 32'd1);
        check("t6_data", {24'd0, rnd_data}, 32'h00);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            metastable_in = 1'($urandom_range(0, 1));
            enable        = ($urandom_range(0, 7) != 0);
            rnd_ready     = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
